// File: rtl/hazard_detect.sv
// hazard_detect: load-use / branch hazard detection with a two-state stall
// FSM, IF/ID squash on taken branches and jumps, and saturating stall/flush
// performance counters. All control outputs are combinational.
module hazard_detect (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_ex,
    input  logic        RegWrite_ex,
    input  logic [4:0]  RegWriteAddr_ex,
    input  logic        MemRead_mem,
    input  logic [4:0]  RegWriteAddr_mem,
    input  logic [4:0]  RsAddr_id,
    input  logic [4:0]  RtAddr_id,
    input  logic        UsesRs_id,
    input  logic        UsesRt_id,
    input  logic        Branch_id,
    input  logic        Taken_id,
    input  logic        Jump_id,
    input  logic        Freeze,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXFlush,
    output logic        IFIDFlush,
    output logic [15:0] StallCnt,
    output logic [15:0] FlushCnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [1:0] remain, remain_next;

    logic       hit_ex, hit_mem;
    logic       haz_lu, haz_ba, haz_bl2, haz_bl1;
    logic [1:0] need;
    logic       hold_active;
    logic       stall;

    // A producer matches only a source the ID instruction really reads; $0 never matches.
    assign hit_ex  = (RegWriteAddr_ex != 5'd0) &&
                     ((UsesRs_id && (RsAddr_id == RegWriteAddr_ex)) ||
                      (UsesRt_id && (RtAddr_id == RegWriteAddr_ex)));
    assign hit_mem = (RegWriteAddr_mem != 5'd0) &&
                     ((UsesRs_id && (RsAddr_id == RegWriteAddr_mem)) ||
                      (UsesRt_id && (RtAddr_id == RegWriteAddr_mem)));

    // Branches compare in ID without EX forwarding, so they wait on ALU results too.
    assign haz_lu  = !Branch_id && MemRead_ex && hit_ex;
    assign haz_ba  = Branch_id && RegWrite_ex && !MemRead_ex && hit_ex;
    assign haz_bl2 = Branch_id && MemRead_ex && hit_ex;
    assign haz_bl1 = Branch_id && MemRead_mem && hit_mem;

    assign need = haz_bl2                      ? 2'd2 :
                  (haz_lu || haz_ba || haz_bl1) ? 2'd1 : 2'd0;

    // While rst is high the outputs behave as if the FSM were already in RUN.
    assign hold_active = (state == HOLD) && !rst;
    assign stall       = !Freeze && (hold_active || (need != 2'd0));

    // Pipeline enables/flushes; Freeze forces everything low.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IDEXFlush = 1'b0;
        IFIDFlush = 1'b0;
        if (!Freeze) begin
            if (stall) begin
                // The branch outcome is not valid yet, so never squash while stalling.
                IDEXFlush = 1'b1;
            end else begin
                PCWrite   = 1'b1;
                IFIDWrite = 1'b1;
                IFIDFlush = (Branch_id && Taken_id) || Jump_id;
            end
        end
    end

    // Next-state logic: a need of 2 parks in HOLD; HOLD ignores new hazards.
    always_comb begin
        state_next  = state;
        remain_next = remain;
        if (!Freeze) begin
            unique case (state)
                RUN: begin
                    if (need == 2'd2) begin
                        state_next  = HOLD;
                        remain_next = 2'd1;
                    end
                end
                HOLD: begin
                    remain_next = remain - 2'd1;
                    if (remain_next == 2'd0) begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // State register; reset wins over Freeze and aborts any pending stall.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state  <= RUN;
            remain <= 2'd0;
        end else begin
            state  <= state_next;
            remain <= remain_next;
        end
    end

    // Saturating performance counters; both are implicitly held while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCnt <= 16'd0;
            FlushCnt <= 16'd0;
        end else begin
            if (stall && (StallCnt != 16'hFFFF)) begin
                StallCnt <= StallCnt + 16'd1;
            end
            if (IFIDFlush && (FlushCnt != 16'hFFFF)) begin
                FlushCnt <= FlushCnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_detect.sv
// tb_hazard_detect: directed scenarios plus randomized traffic, every cycle
// compared against a pending-stall-count reference model.
module tb_hazard_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_ex, RegWrite_ex, MemRead_mem;
    logic [4:0]  RegWriteAddr_ex, RegWriteAddr_mem, RsAddr_id, RtAddr_id;
    logic        UsesRs_id, UsesRt_id, Branch_id, Taken_id, Jump_id, Freeze;
    logic        PCWrite, IFIDWrite, IDEXFlush, IFIDFlush;
    logic [15:0] StallCnt, FlushCnt;

    int checks = 0;
    int errors = 0;

    // Reference model: number of extra forced stall cycles still owed, plus counts.
    int m_pending = 0;
    int m_stall   = 0;
    int m_flush   = 0;
    bit do_check  = 1'b1;

    hazard_detect dut (
        .clk              (clk),
        .rst              (rst),
        .MemRead_ex       (MemRead_ex),
        .RegWrite_ex      (RegWrite_ex),
        .RegWriteAddr_ex  (RegWriteAddr_ex),
        .MemRead_mem      (MemRead_mem),
        .RegWriteAddr_mem (RegWriteAddr_mem),
        .RsAddr_id        (RsAddr_id),
        .RtAddr_id        (RtAddr_id),
        .UsesRs_id        (UsesRs_id),
        .UsesRt_id        (UsesRt_id),
        .Branch_id        (Branch_id),
        .Taken_id         (Taken_id),
        .Jump_id          (Jump_id),
        .Freeze           (Freeze),
        .PCWrite          (PCWrite),
        .IFIDWrite        (IFIDWrite),
        .IDEXFlush        (IDEXFlush),
        .IFIDFlush        (IFIDFlush),
        .StallCnt         (StallCnt),
        .FlushCnt         (FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && ((UsesRs_id && RsAddr_id == r) || (UsesRt_id && RtAddr_id == r));
    endfunction

    // Cycles of stall demanded by the instruction pair currently presented.
    function automatic int hazard_need();
        int n = 0;
        if (!Branch_id && MemRead_ex && reads(RegWriteAddr_ex)) n = (n > 1) ? n : 1;
        if (Branch_id && RegWrite_ex && !MemRead_ex && reads(RegWriteAddr_ex)) n = (n > 1) ? n : 1;
        if (Branch_id && MemRead_ex && reads(RegWriteAddr_ex)) n = 2;
        if (Branch_id && MemRead_mem && reads(RegWriteAddr_mem)) n = (n > 1) ? n : 1;
        return n;
    endfunction

    task automatic set_idle();
        rst = 0; MemRead_ex = 0; RegWrite_ex = 0; RegWriteAddr_ex = 0;
        MemRead_mem = 0; RegWriteAddr_mem = 0; RsAddr_id = 0; RtAddr_id = 0;
        UsesRs_id = 0; UsesRt_id = 0; Branch_id = 0; Taken_id = 0; Jump_id = 0;
        Freeze = 0;
    endtask

    // Called just after a falling edge with inputs driven: check, clock, update model.
    task automatic step();
        int need;
        bit st, fl;
        #1;
        need = hazard_need();
        if (Freeze) begin
            st = 0;
            fl = 0;
        end else begin
            st = (!rst && m_pending > 0) || (need > 0);
            fl = !st && ((Branch_id && Taken_id) || Jump_id);
        end
        if (do_check) begin
            check("pcwrite",   {15'd0, PCWrite},   {15'd0, !Freeze && !st});
            check("ifidwrite", {15'd0, IFIDWrite}, {15'd0, !Freeze && !st});
            check("idexflush", {15'd0, IDEXFlush}, {15'd0, st});
            check("ifidflush", {15'd0, IFIDFlush}, {15'd0, fl});
            check("stall_cnt", StallCnt, 16'(m_stall));
            check("flush_cnt", FlushCnt, 16'(m_flush));
        end
        @(posedge clk);
        if (rst) begin
            m_pending = 0;
            m_stall   = 0;
            m_flush   = 0;
        end else if (!Freeze) begin
            if (m_pending > 0) m_pending--;
            else if (need > 0) m_pending = need - 1;
            if (st && m_stall < 65535) m_stall++;
            if (fl && m_flush < 65535) m_flush++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    // lw $9 in EX, beq $9,$0 in ID.
    task automatic bl2_first();
        set_idle();
        MemRead_ex = 1; RegWrite_ex = 1; RegWriteAddr_ex = 5'd9;
        Branch_id = 1; RsAddr_id = 5'd9; UsesRs_id = 1; UsesRt_id = 1;
    endtask

    // One cycle later: bubble in EX, the load now in MEM.
    task automatic bl2_second();
        set_idle();
        MemRead_mem = 1; RegWriteAddr_mem = 5'd9;
        Branch_id = 1; RsAddr_id = 5'd9; UsesRs_id = 1; UsesRt_id = 1;
    endtask

    initial begin
        set_idle();
        rst = 1;
        @(negedge clk);
        do_check = 0;
        step();
        do_check = 1;
        step();
        rst = 0;

        // Reset state
        #1;
        check("rst_pcwrite", {15'd0, PCWrite}, 16'd1);
        check("rst_stall_cnt", StallCnt, 16'd0);
        check("rst_flush_cnt", FlushCnt, 16'd0);
        step();

        // Load-use: lw $8 then add reading $8
        MemRead_ex = 1; RegWrite_ex = 1; RegWriteAddr_ex = 5'd8;
        RsAddr_id = 5'd8; UsesRs_id = 1;
        #1;
        check("lu_pcwrite", {15'd0, PCWrite}, 16'd0);
        check("lu_idexflush", {15'd0, IDEXFlush}, 16'd1);
        step();
        set_idle();
        MemRead_mem = 1; RegWriteAddr_mem = 5'd8; RsAddr_id = 5'd8; UsesRs_id = 1;
        #1;
        check("lu_release", {15'd0, PCWrite}, 16'd1);
        check("lu_stall_cnt", StallCnt, 16'd1);
        step();

        // Register zero never matches
        set_idle();
        MemRead_ex = 1; RegWriteAddr_ex = 5'd0; RsAddr_id = 5'd0; UsesRs_id = 1;
        #1;
        check("r0_pcwrite", {15'd0, PCWrite}, 16'd1);
        check("r0_idexflush", {15'd0, IDEXFlush}, 16'd0);
        step();

        // Unused source does not match
        set_idle();
        MemRead_ex = 1; RegWriteAddr_ex = 5'd5; RtAddr_id = 5'd5; UsesRt_id = 0;
        #1;
        check("unused_src", {15'd0, PCWrite}, 16'd1);
        step();

        // Reset beats Freeze
        set_idle();
        rst = 1; Freeze = 1;
        step();
        set_idle();
        #1;
        check("rst_over_freeze", StallCnt, 16'd0);
        step();

        // Branch after load: two stalls, then taken branch squashes IF/ID
        do_reset();
        bl2_first();
        #1;
        check("bl2_stall1", {15'd0, IDEXFlush}, 16'd1);
        step();
        bl2_second();
        #1;
        check("bl2_stall2", {15'd0, PCWrite}, 16'd0);
        check("bl2_no_squash", {15'd0, IFIDFlush}, 16'd0);
        step();
        set_idle();
        Branch_id = 1; RsAddr_id = 5'd9; UsesRs_id = 1; Taken_id = 1;
        #1;
        check("bl2_taken_flush", {15'd0, IFIDFlush}, 16'd1);
        check("bl2_taken_pc", {15'd0, PCWrite}, 16'd1);
        step();
        set_idle();
        #1;
        check("bl2_stall_cnt", StallCnt, 16'd2);
        check("bl2_flush_cnt", FlushCnt, 16'd1);
        check("bl2_flush_once", {15'd0, IFIDFlush}, 16'd0);
        step();

        // Freeze in the middle of HOLD
        do_reset();
        bl2_first();
        step();
        for (int i = 0; i < 3; i++) begin
            bl2_second();
            Freeze = 1;
            #1;
            check("frz_pcwrite", {15'd0, PCWrite}, 16'd0);
            check("frz_idexflush", {15'd0, IDEXFlush}, 16'd0);
            check("frz_stall_cnt", StallCnt, 16'd1);
            step();
        end
        bl2_second();
        #1;
        check("frz_resume_stall", {15'd0, IDEXFlush}, 16'd1);
        step();
        set_idle();
        #1;
        check("frz_done_pc", {15'd0, PCWrite}, 16'd1);
        check("frz_done_cnt", StallCnt, 16'd2);
        step();

        // Reset during HOLD aborts the remaining stall
        do_reset();
        bl2_first();
        step();
        set_idle();
        rst = 1;
        #1;
        check("rst_hold_pc", {15'd0, PCWrite}, 16'd1);
        step();
        set_idle();
        #1;
        check("post_rst_pc", {15'd0, PCWrite}, 16'd1);
        check("post_rst_idex", {15'd0, IDEXFlush}, 16'd0);
        check("post_rst_cnt", StallCnt, 16'd0);
        step();

        // Randomized traffic over a small register set to provoke matches
        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 39) == 0);
            Freeze           = ($urandom_range(0, 7) == 0);
            MemRead_ex       = 1'($urandom_range(0, 1));
            RegWrite_ex      = 1'($urandom_range(0, 1));
            RegWriteAddr_ex  = 5'($urandom_range(0, 3));
            MemRead_mem      = 1'($urandom_range(0, 1));
            RegWriteAddr_mem = 5'($urandom_range(0, 3));
            RsAddr_id        = 5'($urandom_range(0, 3));
            RtAddr_id        = 5'($urandom_range(0, 3));
            UsesRs_id        = 1'($urandom_range(0, 1));
            UsesRt_id        = 1'($urandom_range(0, 1));
            Branch_id        = 1'($urandom_range(0, 1));
            Taken_id         = 1'($urandom_range(0, 1));
            Jump_id          = ($urandom_range(0, 5) == 0);
            step();
        end

        // Stall counter saturation
        do_reset();
        MemRead_ex = 1; RegWriteAddr_ex = 5'd8; RsAddr_id = 5'd8; UsesRs_id = 1;
        do_check = 0;
        for (int i = 0; i < 65534; i++) step();
        do_check = 1;
        #1;
        check("sat_preload", StallCnt, 16'd65534);
        for (int i = 0; i < 3; i++) step();
        set_idle();
        #1;
        check("sat_held", StallCnt, 16'hFFFF);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
